shift_reg_univ: RTL and testbench

Parametrised universal shift register: DEPTH stages of WIDTH bits each, with hold, bidirectional shift, rotate, parallel load and clear modes. It also keeps a saturating fill count of valid stages. This is the second-generation serial/delay-line element for the design. The default parameters give a 4-stage, 1-bit register whose shift-up mode reproduces the fixed first-generation d→q0→q1→q2→q3 chain.

---
 rtl/shift_pkg.sv | 34 +++
 rtl/shift_fill_ctr.sv | 57 +++++
 rtl/shift_reg_univ.sv | 148 ++++++++++++++
 tb/tb_shift_reg_univ.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
//
// Shared definitions for the universal shift register family.
//
// Contents:
//   MODE_W  - width of the mode select bus.
//   mode_e  - operation encodings used by shift_reg_univ and its bench.
//
// Encoding 7 is reserved. The register treats it exactly like HOLD, so a
// future mode can be added without changing the behaviour of existing code.
// ---------------------------------------------------------------------------
package shift_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD  = 3'd0,  // keep all stages
        MODE_SHUP  = 3'd1,  // s[0] <- sin_lo, s[i] <- s[i-1]
        MODE_SHDN  = 3'd2,  // s[DEPTH-1] <- sin_hi, s[i] <- s[i+1]
        MODE_ROTUP = 3'd3,  // s[0] <- s[DEPTH-1], s[i] <- s[i-1]
        MODE_ROTDN = 3'd4,  // s[DEPTH-1] <- s[0], s[i] <- s[i+1]
        MODE_LOAD  = 3'd5,  // s <- pdata
        MODE_CLEAR = 3'd6,  // s <- 0
        MODE_RSVD  = 3'd7   // reserved, behaves as HOLD
    } mode_e;

    // True for the two modes that push a new serial value into the array
    // and therefore advance the fill count.
    function automatic logic is_shift(input mode_e m);
        return (m == MODE_SHUP) || (m == MODE_SHDN);
    endfunction

endpackage

// File: rtl/shift_fill_ctr.sv
// ---------------------------------------------------------------------------
// shift_fill_ctr
//
// Saturating count of valid stages in the universal shift register.
//
// Ports:
//   clk       in   clock, all updates on the rising edge
//   rst       in   synchronous active-high reset, clears fill and full
//   en        in   when low the count and flag hold
//   inc       in   a shift happened: fill <- min(fill+1, DEPTH)
//   set_full  in   a parallel load happened: fill <- DEPTH
//   clr       in   a clear happened: fill <- 0
//   fill      out  FW-bit count, 0..DEPTH
//   full      out  registered flag, high exactly when fill == DEPTH
//
// inc, set_full and clr come from a one-hot mode decode, so at most one is
// high; the if/else order below only matters if that ever changes.
// ---------------------------------------------------------------------------
module shift_fill_ctr #(
    parameter  int DEPTH = 4,
    localparam int FW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          inc,
    input  logic          set_full,
    input  logic          clr,
    output logic [FW-1:0] fill,
    output logic          full
);

    localparam logic [FW-1:0] FILL_MAX  = FW'(DEPTH);
    localparam logic [FW-1:0] FILL_LAST = FW'(DEPTH - 1);

    // full is kept as its own register rather than decoded from fill so that
    // the output is a flop and not a comparator hanging off the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill <= '0;
            full <= 1'b0;
        end else if (en) begin
            if (clr) begin
                fill <= '0;
                full <= 1'b0;
            end else if (set_full) begin
                fill <= FILL_MAX;
                full <= 1'b1;
            end else if (inc && !full) begin
                // Saturating: once full, further shifts leave the count alone.
                fill <= fill + FW'(1);
                full <= (fill == FILL_LAST);
            end
        end
    end

endmodule

// File: rtl/shift_reg_univ.sv
// ---------------------------------------------------------------------------
// shift_reg_univ
//
// Universal shift register: DEPTH stages of WIDTH bits with hold, shift
// up/down, rotate up/down, parallel load and clear, plus a saturating count
// of valid stages. With default parameters SHUP reproduces the original
// 4-stage 1-bit d->q0->q1->q2->q3 delay chain.
//
// Parameters:
//   WIDTH  bits per stage, >= 1
//   DEPTH  number of stages, >= 2
//   FW     fill-count width, derived from DEPTH
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (highest priority)
//   en       in   operation enable; low freezes every register
//   mode     in   operation select, see shift_pkg::mode_e
//   sin_lo   in   serial data entering stage 0 on SHUP
//   sin_hi   in   serial data entering stage DEPTH-1 on SHDN
//   pdata    in   parallel load data, stage i at [i*WIDTH +: WIDTH]
//   q        out  all stages, same packing as pdata
//   sout_lo  out  stage 0
//   sout_hi  out  stage DEPTH-1
//   fill     out  number of valid stages, 0..DEPTH
//   full     out  fill == DEPTH
//
// Transfer semantics: en is the only qualifier. An operation is taken on
// every rising edge where rst=0 and en=1; there is no back-pressure and no
// acknowledge, and results are visible on the outputs after that edge.
// All outputs are driven directly by flops.
// ---------------------------------------------------------------------------
module shift_reg_univ
    import shift_pkg::*;
#(
    parameter  int WIDTH = 1,
    parameter  int DEPTH = 4,
    localparam int FW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [MODE_W-1:0]      mode,
    input  logic [WIDTH-1:0]       sin_lo,
    input  logic [WIDTH-1:0]       sin_hi,
    input  logic [DEPTH*WIDTH-1:0] pdata,
    output logic [DEPTH*WIDTH-1:0] q,
    output logic [WIDTH-1:0]       sout_lo,
    output logic [WIDTH-1:0]       sout_hi,
    output logic [FW-1:0]          fill,
    output logic                   full
);

    // Stage storage. Packed so that s[i] lines up with q[i*WIDTH +: WIDTH].
    logic [DEPTH-1:0][WIDTH-1:0] s;
    logic [DEPTH-1:0][WIDTH-1:0] s_nxt;

    mode_e op;
    assign op = mode_e'(mode);

    // -----------------------------------------------------------------------
    // Per-stage next-value mux. Each stage sees a neighbour from below (used
    // by SHUP/ROTUP) and from above (SHDN/ROTDN). Interior stages take both
    // from the adjacent stage; the two end stages swap in the serial input
    // for a shift or the opposite end of the array for a rotate.
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [WIDTH-1:0] shup_src;
        logic [WIDTH-1:0] rotup_src;
        logic [WIDTH-1:0] shdn_src;
        logic [WIDTH-1:0] rotdn_src;
        logic [WIDTH-1:0] stage_nxt;

        if (g == 0) begin : g_below
            assign shup_src  = sin_lo;
            assign rotup_src = s[DEPTH-1];
        end else begin : g_below
            assign shup_src  = s[g-1];
            assign rotup_src = s[g-1];
        end

        if (g == DEPTH - 1) begin : g_above
            assign shdn_src  = sin_hi;
            assign rotdn_src = s[0];
        end else begin : g_above
            assign shdn_src  = s[g+1];
            assign rotdn_src = s[g+1];
        end

        always_comb begin
            stage_nxt = s[g];
            case (op)
                MODE_SHUP:  stage_nxt = shup_src;
                MODE_SHDN:  stage_nxt = shdn_src;
                MODE_ROTUP: stage_nxt = rotup_src;
                MODE_ROTDN: stage_nxt = rotdn_src;
                MODE_LOAD:  stage_nxt = pdata[g*WIDTH +: WIDTH];
                MODE_CLEAR: stage_nxt = '0;
                default:    stage_nxt = s[g];  // HOLD and reserved
            endcase
        end

        assign s_nxt[g] = stage_nxt;
    end

    // Reset beats enable, enable beats mode. A shift that is in the same
    // cycle as rst is simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            s <= '0;
        end else if (en) begin
            s <= s_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Fill count. Direction of the shift is irrelevant; rotates and HOLD
    // leave it alone because they neither add nor drop data.
    // -----------------------------------------------------------------------
    logic fc_inc;
    logic fc_set_full;
    logic fc_clr;

    always_comb begin
        fc_inc      = is_shift(op);
        fc_set_full = (op == MODE_LOAD);
        fc_clr      = (op == MODE_CLEAR);
    end

    shift_fill_ctr #(
        .DEPTH(DEPTH)
    ) u_fill (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .inc      (fc_inc),
        .set_full (fc_set_full),
        .clr      (fc_clr),
        .fill     (fill),
        .full     (full)
    );

    // Outputs are plain wires off the stage flops.
    assign q       = s;
    assign sout_lo = s[0];
    assign sout_hi = s[DEPTH-1];

endmodule

// File: tb/tb_shift_reg_univ.sv
// ---------------------------------------------------------------------------
// tb_shift_reg_univ
//
// Two instances share one clock: u_w8 (WIDTH=8, DEPTH=4) and u_w1 (WIDTH=1,
// DEPTH=4). The driver applies one operation per cycle to the selected
// instance (the other holds with en=0), steps a queue-based reference model
// and pushes the expected outputs. The monitor pops one expectation per
// falling edge and compares it with the selected instance.
// ---------------------------------------------------------------------------
module tb_shift_reg_univ;
    import shift_pkg::*;

    localparam int DEPTH = 4;

    // ---------------- clock / reset block ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic        rst0, en0;
    logic [2:0]  mode0;
    logic [7:0]  sin_lo0, sin_hi0;
    logic [31:0] pdata0, q0;
    logic [7:0]  sout_lo0, sout_hi0;
    logic [2:0]  fill0;
    logic        full0;

    // 1-bit instance
    logic        rst1, en1;
    logic [2:0]  mode1;
    logic [0:0]  sin_lo1, sin_hi1;
    logic [3:0]  pdata1, q1;
    logic [0:0]  sout_lo1, sout_hi1;
    logic [2:0]  fill1;
    logic        full1;

    shift_reg_univ #(.WIDTH(8), .DEPTH(DEPTH)) u_w8 (
        .clk(clk), .rst(rst0), .en(en0), .mode(mode0),
        .sin_lo(sin_lo0), .sin_hi(sin_hi0), .pdata(pdata0),
        .q(q0), .sout_lo(sout_lo0), .sout_hi(sout_hi0),
        .fill(fill0), .full(full0)
    );

    shift_reg_univ #(.WIDTH(1), .DEPTH(DEPTH)) u_w1 (
        .clk(clk), .rst(rst1), .en(en1), .mode(mode1),
        .sin_lo(sin_lo1), .sin_hi(sin_hi1), .pdata(pdata1),
        .q(q1), .sout_lo(sout_lo1), .sout_hi(sout_hi1),
        .fill(fill1), .full(full1)
    );

    // ---------------- scoreboard state ----------------
    // Entry: {sel, q[31:0], sout_lo[7:0], sout_hi[7:0], fill[2:0], full}
    logic [52:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    string       tname    = "idle";

    // Reference model: one queue of stage values per instance, index 0 is
    // stage 0. Shifts and rotates are queue pushes and pops.
    logic [7:0] m0[$];
    logic [7:0] m1[$];
    int         f0 = 0;
    int         f1 = 0;

    function automatic logic [51:0] pack(input logic [31:0] q, input logic [7:0] lo,
                                         input logic [7:0] hi, input logic [2:0] f,
                                         input logic fl);
        return {q, lo, hi, f, fl};
    endfunction

    task automatic model_apply(input int sel, input logic r, input logic e,
                               input logic [2:0] md, input logic [7:0] sl,
                               input logic [7:0] sh, input logic [31:0] pd,
                               output logic [51:0] exp_v);
        logic [7:0]  mq[$];
        logic [7:0]  t;
        logic [7:0]  mask;
        logic [31:0] qv;
        int          mf;
        int          w;
        w    = (sel != 0) ? 1 : 8;
        mask = (sel != 0) ? 8'h01 : 8'hFF;
        if (sel == 0) begin mq = m0; mf = f0; end
        else          begin mq = m1; mf = f1; end
        if (r) begin
            mq = '{8'h00, 8'h00, 8'h00, 8'h00};
            mf = 0;
        end else if (e) begin
            case (md)
                3'd1: begin
                    mq.push_front(sl & mask);
                    void'(mq.pop_back());
                    mf = (mf < DEPTH) ? mf + 1 : DEPTH;
                end
                3'd2: begin
                    mq.push_back(sh & mask);
                    void'(mq.pop_front());
                    mf = (mf < DEPTH) ? mf + 1 : DEPTH;
                end
                3'd3: begin
                    t = mq.pop_back();
                    mq.push_front(t);
                end
                3'd4: begin
                    t = mq.pop_front();
                    mq.push_back(t);
                end
                3'd5: begin
                    mq.delete();
                    for (int i = 0; i < DEPTH; i++)
                        mq.push_back(8'((pd >> (i * w)) & {24'h0, mask}));
                    mf = DEPTH;
                end
                3'd6: begin
                    mq = '{8'h00, 8'h00, 8'h00, 8'h00};
                    mf = 0;
                end
                default: ;
            endcase
        end
        qv = 32'h0;
        for (int i = 0; i < DEPTH; i++)
            qv = qv | (32'(mq[i]) << (i * w));
        exp_v = pack(qv, mq[0], mq[DEPTH-1], 3'(mf), (mf == DEPTH));
        if (sel == 0) begin m0 = mq; f0 = mf; end
        else          begin m1 = mq; f1 = mf; end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input int sel, input logic r, input logic e,
                         input logic [2:0] md, input logic [7:0] sl,
                         input logic [7:0] sh, input logic [31:0] pd);
        logic [51:0] ev;
        @(negedge clk);
        #1;
        rst0 = 1'b0; en0 = 1'b0;
        rst1 = 1'b0; en1 = 1'b0;
        if (sel == 0) begin
            rst0 = r; en0 = e; mode0 = md;
            sin_lo0 = sl; sin_hi0 = sh; pdata0 = pd;
        end else begin
            rst1 = r; en1 = e; mode1 = md;
            sin_lo1 = sl[0]; sin_hi1 = sh[0]; pdata1 = pd[3:0];
        end
        model_apply(sel, r, e, md, sl, sh, pd, ev);
        exp_q.push_back({(sel != 0), ev});
    endtask

    task automatic op(input int sel, input logic [2:0] md, input logic [7:0] sl,
                      input logic [7:0] sh, input logic [31:0] pd);
        drive(sel, 1'b0, 1'b1, md, sl, sh, pd);
    endtask

    task automatic do_rst(input int sel);
        drive(sel, 1'b1, 1'b1, 3'd1, 8'hFF, 8'hFF, 32'hFFFF_FFFF);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [52:0] e;
        logic [51:0] act;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e[52])
                act = pack({28'h0, q1}, {7'h0, sout_lo1}, {7'h0, sout_hi1}, fill1, full1);
            else
                act = pack(q0, sout_lo0, sout_hi0, fill0, full0);
            checks++;
            if (act !== e[51:0]) begin
                failures++;
                $display("FAIL %s inst=%0d got q=%h lo=%h hi=%h fill=%0d full=%0b want q=%h lo=%h hi=%h fill=%0d full=%0b",
                         tname, e[52], act[51:20], act[19:12], act[11:4], act[3:1], act[0],
                         e[51:20], e[19:12], e[11:4], e[3:1], e[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst0 = 1'b1; en0 = 1'b0; mode0 = 3'd0; sin_lo0 = '0; sin_hi0 = '0; pdata0 = '0;
        rst1 = 1'b1; en1 = 1'b0; mode1 = 3'd0; sin_lo1 = '0; sin_hi1 = '0; pdata1 = '0;
        m0 = '{8'h00, 8'h00, 8'h00, 8'h00};
        m1 = '{8'h00, 8'h00, 8'h00, 8'h00};

        // Reset/defaults on the 1-bit instance: one 1 then three 0s.
        tname = "w1_reset";  do_rst(1);
        tname = "w1_shup";   op(1, MODE_SHUP, 8'h01, 8'h00, 32'h0);
        for (int i = 0; i < 3; i++) op(1, MODE_SHUP, 8'h00, 8'h00, 32'h0);
        tname = "w1_rand";
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 19) == 0) do_rst(1);
            else drive(1, 1'b0, ($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)),
                       8'($urandom), 8'($urandom), $urandom);
        end

        // Bidirectional shift.
        tname = "w8_reset";  do_rst(0);
        tname = "load";      op(0, MODE_LOAD, 8'h00, 8'h00, 32'h4433_2211);
        tname = "shdn";      op(0, MODE_SHDN, 8'h00, 8'hAA, 32'h0);

        // Rotate conservation.
        tname = "load2";     op(0, MODE_LOAD, 8'h00, 8'h00, 32'h0403_0201);
        tname = "rotup";
        for (int i = 0; i < 4; i++) op(0, MODE_ROTUP, 8'h5A, 8'hA5, 32'h0);
        tname = "rotdn";
        for (int i = 0; i < 4; i++) op(0, MODE_ROTDN, 8'h5A, 8'hA5, 32'h0);

        // Enable low, then reserved mode.
        tname = "en_low";
        for (int i = 0; i < 5; i++) drive(0, 1'b0, 1'b0, MODE_SHUP, 8'h77, 8'h66, 32'h0);
        tname = "reserved";
        for (int i = 0; i < 2; i++) op(0, MODE_RSVD, 8'h77, 8'h66, 32'hDEAD_BEEF);

        // Clear and saturation.
        tname = "clear";     op(0, MODE_CLEAR, 8'h00, 8'h00, 32'h0);
        tname = "saturate";
        for (int i = 0; i < 6; i++) op(0, MODE_SHUP, 8'($urandom), 8'h00, 32'h0);
        tname = "rot_full";  op(0, MODE_ROTUP, 8'h00, 8'h00, 32'h0);

        // Reset in the middle of a shift burst.
        tname = "mid_rst";
        op(0, MODE_CLEAR, 8'h00, 8'h00, 32'h0);
        op(0, MODE_SHUP, 8'h11, 8'h00, 32'h0);
        op(0, MODE_SHUP, 8'h22, 8'h00, 32'h0);
        do_rst(0);
        op(0, MODE_SHUP, 8'h33, 8'h00, 32'h0);

        // Mixed up/down shifting counts toward fill regardless of direction.
        tname = "updown";
        op(0, MODE_CLEAR, 8'h00, 8'h00, 32'h0);
        op(0, MODE_SHUP, 8'hC1, 8'h00, 32'h0);
        op(0, MODE_SHDN, 8'h00, 8'hC2, 32'h0);

        // Random operations, mode changing every cycle.
        tname = "w8_rand";
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) do_rst(0);
            else drive(0, 1'b0, ($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)),
                       8'($urandom), 8'($urandom), $urandom);
        end

        // Let the monitor drain the last expectations.
        tname = "drain";
        drive(0, 1'b0, 1'b0, MODE_HOLD, 8'h00, 8'h00, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain leftover=%0d want=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
